// File: rtl/mips_regfile_write_driver_if.sv
// Bundles the request handshake, register-file write port, status and bypass
// signals of mips_regfile_write_driver; the driver uses the slave modport.
interface mips_regfile_write_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_reg;
  logic [31:0] req_data;

  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        signal_reg_write;

  logic        clearing;
  logic        busy;

  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic        byp_hit_1;
  logic        byp_hit_2;
  logic [31:0] byp_data_1;
  logic [31:0] byp_data_2;

  modport slave (
    input  req_valid, req_reg, req_data, read_reg_1, read_reg_2,
    output req_ready, write_reg, write_data, signal_reg_write,
           clearing, busy, byp_hit_1, byp_hit_2, byp_data_1, byp_data_2
  );

  modport master (
    output req_valid, req_reg, req_data, read_reg_1, read_reg_2,
    input  req_ready, write_reg, write_data, signal_reg_write,
           clearing, busy, byp_hit_1, byp_hit_2, byp_data_1, byp_data_2
  );
endinterface

// File: rtl/mips_regfile_write_driver.sv
// Write-side initiator for mips_registers: FIFO-buffered requests, post-reset clear
// of r1..r31, one write per clock. Define MIPS_WBQ_BYPASS_EN for pending-write bypass.
module mips_regfile_write_driver #(
  parameter int DEPTH          = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  mips_regfile_write_driver_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t         state_q;
  logic [4:0]     clr_cnt_q;
  logic [AW-1:0]  wptr_q;
  logic [AW-1:0]  rptr_q;
  logic [CW-1:0]  count_q;
  logic [4:0]     fifo_reg_q  [DEPTH];
  logic [31:0]    fifo_data_q [DEPTH];
  logic [4:0]     wr_reg_q;
  logic [31:0]    wr_data_q;
  logic           wr_en_q;
  logic           clearing_q;

  logic full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // clearing_q also covers the cycle that shows the r31 clear write, so the
  // pipeline is only admitted once the clear write port is quiet.
  assign bus.req_ready = (state_q == S_RUN) && !clearing_q && !full;
  assign push          = bus.req_valid && bus.req_ready && (bus.req_reg != 5'd0);
  assign pop           = (state_q == S_RUN) && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      clr_cnt_q  <= 5'd1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      clearing_q <= 1'b0;
    end else begin
      clearing_q <= (state_q == S_CLEAR);
      case (state_q)
        S_CLEAR: begin
          wr_en_q   <= 1'b1;
          wr_reg_q  <= clr_cnt_q;
          wr_data_q <= '0;
          clr_cnt_q <= clr_cnt_q + 5'd1;
          if (clr_cnt_q == 5'd31) state_q <= S_RUN;
        end
        S_RUN: begin
          wr_en_q <= pop;
          if (pop) begin
            wr_reg_q  <= fifo_reg_q[rptr_q];
            wr_data_q <= fifo_data_q[rptr_q];
            rptr_q    <= rptr_q + AW'(1);
          end
        end
        default: state_q <= S_RUN;
      endcase

      if (push) wptr_q <= wptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[wptr_q]  <= bus.req_reg;
      fifo_data_q[wptr_q] <= bus.req_data;
    end
  end

  assign bus.write_reg        = wr_reg_q;
  assign bus.write_data       = wr_data_q;
  assign bus.signal_reg_write = wr_en_q;
  assign bus.clearing         = clearing_q;
  assign bus.busy             = clearing_q || !empty || wr_en_q;

`ifdef MIPS_WBQ_BYPASS_EN
  // Scan oldest to youngest (output register, then FIFO head..tail) so the
  // last match wins; clear writes carry zero data, which covers the CLEAR case.
  function automatic logic [32:0] byp_lookup(input logic [4:0] rd);
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = '0;
    if (wr_en_q && (wr_reg_q == rd)) res = {1'b1, wr_data_q};
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + AW'(i);
      if ((CW'(i) < count_q) && (fifo_reg_q[idx] == rd)) res = {1'b1, fifo_data_q[idx]};
    end
    if (rd == 5'd0) res = '0;
    return res;
  endfunction

  logic [32:0] byp1, byp2;

  always_comb begin
    byp1 = byp_lookup(bus.read_reg_1);
    byp2 = byp_lookup(bus.read_reg_2);
  end

  assign bus.byp_hit_1  = byp1[32];
  assign bus.byp_data_1 = byp1[31:0];
  assign bus.byp_hit_2  = byp2[32];
  assign bus.byp_data_2 = byp2[31:0];
`else
  assign bus.byp_hit_1  = 1'b0;
  assign bus.byp_data_1 = '0;
  assign bus.byp_hit_2  = 1'b0;
  assign bus.byp_data_2 = '0;
`endif

endmodule
